// File: rtl/ibpl_out_pkg.sv
// Shared types and default parameters for the interbackplane output cardlet.
package ibpl_out_pkg;

    // Per-channel drive mode, two bits per channel on ch_mode
    typedef enum logic [1:0] {
        MODE_DIRECT  = 2'd0,
        MODE_STRETCH = 2'd1,
        MODE_TOGGLE  = 2'd2,
        MODE_INVERT  = 2'd3
    } ch_mode_t;

    localparam int DEF_N_CH     = 6;
    localparam int DEF_CNT_W    = 16;
    localparam int DEF_LED_HOLD = 125000;

endpackage

// File: rtl/ibpl_out_ctrl_if.sv
// Bus bundle between internal logic (master) and the output cardlet (slave).
interface ibpl_out_ctrl_if
    import ibpl_out_pkg::*;
#(
    parameter int N_CH  = DEF_N_CH,
    parameter int CNT_W = DEF_CNT_W
);
    logic [N_CH-1:0]   internal_out;
    logic [N_CH-1:0]   output_enable;
    logic [N_CH-1:0]   input_enable;
    logic [2*N_CH-1:0] ch_mode;
    logic [CNT_W-1:0]  stretch_len;
    logic              err_clr;
    logic [N_CH-1:0]   diob_dir;
    logic [N_CH-1:0]   diob_out;
    logic [N_CH-1:0]   internal_in;
    logic [N_CH-1:0]   diob_led1;
    logic [N_CH-1:0]   diob_led2;
    logic              plugin_error;
    logic              plugin_error_sticky;

    modport master (
        output internal_out, output_enable, input_enable, ch_mode, stretch_len, err_clr,
        input  diob_dir, diob_out, internal_in, diob_led1, diob_led2,
               plugin_error, plugin_error_sticky
    );

    modport slave (
        input  internal_out, output_enable, input_enable, ch_mode, stretch_len, err_clr,
        output diob_dir, diob_out, internal_in, diob_led1, diob_led2,
               plugin_error, plugin_error_sticky
    );
endinterface

// File: rtl/ibpl_out_chan.sv
// One output channel: edge detect, mode mux, stretch counter, toggle state
// and the retriggerable activity-LED monostable.
module ibpl_out_chan
    import ibpl_out_pkg::*;
#(
    parameter int CNT_W    = DEF_CNT_W,
    parameter int LED_HOLD = DEF_LED_HOLD
) (
    input  logic             clk,
    input  logic             nReset,
    input  logic             internal_out,
    input  logic             output_enable,
    input  ch_mode_t         ch_mode,
    input  logic [CNT_W-1:0] stretch_len,
    output logic             diob_out,
    output logic             diob_led2
);
    localparam int LED_W = $clog2(LED_HOLD + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [LED_W-1:0] LED_ZERO = {LED_W{1'b0}};
    localparam logic [LED_W-1:0] LED_ONE  = {{(LED_W-1){1'b0}}, 1'b1};
    localparam logic [LED_W-1:0] LED_LOAD = LED_W'(LED_HOLD);

    logic             prev_r;
    ch_mode_t         mode_prev_r;
    logic             tog_r;
    logic [CNT_W-1:0] cnt_r;
    logic             diob_out_r;
    logic [LED_W-1:0] led_cnt_r;
    logic             led_r;

    logic             edge_s;
    logic             mode_chg_s;
    logic             tog_base_s;
    logic [CNT_W-1:0] cnt_base_s;
    logic             stretching_s;
    logic             core_s;
    logic             drive_s;
    logic             tog_nxt_s;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [LED_W-1:0] led_nxt_s;

    // Next-state and drive value; a mode change wipes the state before this cycle's edge acts on it
    always_comb begin
        edge_s       = internal_out & ~prev_r;
        mode_chg_s   = (ch_mode != mode_prev_r);
        tog_base_s   = 1'b0;
        cnt_base_s   = CNT_ZERO;
        core_s       = 1'b0;
        tog_nxt_s    = 1'b0;
        cnt_nxt_s    = CNT_ZERO;
        led_nxt_s    = LED_ZERO;

        if (mode_chg_s) begin
            tog_base_s = 1'b0;
            cnt_base_s = CNT_ZERO;
        end else begin
            tog_base_s = tog_r;
            cnt_base_s = cnt_r;
        end
        stretching_s = (cnt_base_s != CNT_ZERO);

        case (ch_mode)
            MODE_DIRECT:  core_s = internal_out;
            MODE_STRETCH: core_s = internal_out | stretching_s;
            MODE_TOGGLE:  core_s = tog_base_s ^ edge_s;
            MODE_INVERT:  core_s = ~internal_out;
            default:      core_s = internal_out;
        endcase
        drive_s = output_enable & core_s;

        if (!output_enable) begin
            tog_nxt_s = 1'b0;
            cnt_nxt_s = CNT_ZERO;
        end else begin
            if (ch_mode == MODE_TOGGLE) begin
                tog_nxt_s = tog_base_s ^ edge_s;
            end else begin
                tog_nxt_s = 1'b0;
            end
            // The pulse cycle itself is high through internal_out, so the counter covers L-1 more cycles
            if ((ch_mode == MODE_STRETCH) && edge_s) begin
                if (stretch_len == CNT_ZERO) begin
                    cnt_nxt_s = CNT_ZERO;
                end else begin
                    cnt_nxt_s = stretch_len - CNT_ONE;
                end
            end else if (stretching_s) begin
                cnt_nxt_s = cnt_base_s - CNT_ONE;
            end else begin
                cnt_nxt_s = CNT_ZERO;
            end
        end

        // LED counter reloads in step with the output register so the LED rises with the change
        if (drive_s != diob_out_r) begin
            led_nxt_s = LED_LOAD;
        end else if (led_cnt_r != LED_ZERO) begin
            led_nxt_s = led_cnt_r - LED_ONE;
        end else begin
            led_nxt_s = LED_ZERO;
        end
    end

    // Channel state and registered outputs
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            prev_r      <= 1'b0;
            mode_prev_r <= MODE_DIRECT;
            tog_r       <= 1'b0;
            cnt_r       <= CNT_ZERO;
            diob_out_r  <= 1'b0;
            led_cnt_r   <= LED_ZERO;
            led_r       <= 1'b0;
        end else begin
            prev_r      <= internal_out;
            mode_prev_r <= ch_mode;
            tog_r       <= tog_nxt_s;
            cnt_r       <= cnt_nxt_s;
            diob_out_r  <= drive_s;
            led_cnt_r   <= led_nxt_s;
            led_r       <= (led_nxt_s != LED_ZERO);
        end
    end

    assign diob_out  = diob_out_r;
    assign diob_led2 = led_r;

endmodule

// File: rtl/ibpl_out_ctrl.sv
// Interbackplane output cardlet top: per-channel drivers, enable LEDs,
// enable-mismatch error reporting and the constant direction/input lines.
module ibpl_out_ctrl
    import ibpl_out_pkg::*;
#(
    parameter int N_CH     = DEF_N_CH,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int LED_HOLD = DEF_LED_HOLD
) (
    input  logic           clk,
    input  logic           nReset,
    ibpl_out_ctrl_if.slave bus
);
    logic [N_CH-1:0] diob_out_s;
    logic [N_CH-1:0] diob_led2_s;
    logic [N_CH-1:0] diob_led1_r;
    logic            plugin_error_r;
    logic            plugin_error_sticky_r;

    for (genvar i = 0; i < N_CH; i++) begin : g_chan
        ibpl_out_chan #(
            .CNT_W    (CNT_W),
            .LED_HOLD (LED_HOLD)
        ) u_chan (
            .clk           (clk),
            .nReset        (nReset),
            .internal_out  (bus.internal_out[i]),
            .output_enable (bus.output_enable[i]),
            .ch_mode       (ch_mode_t'(bus.ch_mode[2*i +: 2])),
            .stretch_len   (bus.stretch_len),
            .diob_out      (diob_out_s[i]),
            .diob_led2     (diob_led2_s[i])
        );
    end

    // Enable LED copy, live mismatch error and its sticky latch (set beats clear)
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            diob_led1_r           <= {N_CH{1'b0}};
            plugin_error_r        <= 1'b0;
            plugin_error_sticky_r <= 1'b0;
        end else begin
            diob_led1_r    <= bus.output_enable;
            plugin_error_r <= |(bus.input_enable & ~bus.output_enable);
            if (plugin_error_r) begin
                plugin_error_sticky_r <= 1'b1;
            end else if (bus.err_clr) begin
                plugin_error_sticky_r <= 1'b0;
            end else begin
                plugin_error_sticky_r <= plugin_error_sticky_r;
            end
        end
    end

    assign bus.diob_dir            = {N_CH{1'b1}};
    assign bus.internal_in         = {N_CH{1'b0}};
    assign bus.diob_out            = diob_out_s;
    assign bus.diob_led2           = diob_led2_s;
    assign bus.diob_led1           = diob_led1_r;
    assign bus.plugin_error        = plugin_error_r;
    assign bus.plugin_error_sticky = plugin_error_sticky_r;

endmodule

// File: tb/tb_ibpl_out_ctrl.sv
// Scoreboard bench for ibpl_out_ctrl: stimulus queues expected values tagged
// with the cycle they must appear in, a negedge monitor pops and compares.
module tb_ibpl_out_ctrl;
    import ibpl_out_pkg::*;

    localparam int N_CH     = 6;
    localparam int CNT_W    = 16;
    localparam int LED_HOLD = 4;

    localparam int S_OUT  = 0;
    localparam int S_LED2 = 1;
    localparam int S_LED1 = 2;
    localparam int S_ERR  = 3;
    localparam int S_STK  = 4;
    localparam int S_DIR  = 5;
    localparam int S_IIN  = 6;

    typedef struct {
        int         cyc;
        int         sel;
        logic [5:0] mask;
        logic [5:0] val;
        string      tag;
    } exp_t;

    logic clk    = 1'b0;
    logic nReset = 1'b0;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    ibpl_out_ctrl_if #(.N_CH(N_CH), .CNT_W(CNT_W)) bus();

    ibpl_out_ctrl #(
        .N_CH     (N_CH),
        .CNT_W    (CNT_W),
        .LED_HOLD (LED_HOLD)
    ) dut (
        .clk    (clk),
        .nReset (nReset),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [5:0] observe(int sel);
        case (sel)
            S_OUT:   observe = bus.diob_out;
            S_LED2:  observe = bus.diob_led2;
            S_LED1:  observe = bus.diob_led1;
            S_ERR:   observe = {5'b0, bus.plugin_error};
            S_STK:   observe = {5'b0, bus.plugin_error_sticky};
            S_DIR:   observe = bus.diob_dir;
            S_IIN:   observe = bus.internal_in;
            default: observe = 6'h00;
        endcase
    endfunction

    task automatic push_exp(int at, int sel, logic [5:0] mask, logic [5:0] val, string tag);
        exp_t e;
        e.cyc  = at;
        e.sel  = sel;
        e.mask = mask;
        e.val  = val;
        e.tag  = tag;
        sb.push_back(e);
    endtask

    task automatic tick(int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_mode(int ch, ch_mode_t m);
        bus.ch_mode[2*ch +: 2] = m;
    endtask

    // Monitor: compare every expectation that falls due in this cycle
    always @(negedge clk) begin : monitor
        logic [5:0] act;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc <= cyc) begin
                act = observe(sb[i].sel) & sb[i].mask;
                checks++;
                if ((sb[i].cyc != cyc) || (act != sb[i].val)) begin
                    errors++;
                    $display("FAIL %s cycle %0d (due %0d): got %h, expected %h",
                             sb[i].tag, cyc, sb[i].cyc, act, sb[i].val);
                end
                sb.delete(i);
            end
        end
    end

    initial begin
        int t;
        int u;
        int r;
        bus.internal_out  = 6'h00;
        bus.output_enable = 6'h00;
        bus.input_enable  = 6'h00;
        bus.ch_mode       = 12'h000;
        bus.stretch_len   = 16'd0;
        bus.err_clr       = 1'b0;
        nReset            = 1'b0;
        tick(3);
        nReset = 1'b1;
        tick(1);

        // Reset / idle state
        t = cyc;
        push_exp(t, S_OUT,  6'h3F, 6'h00, "rst_diob_out");
        push_exp(t, S_DIR,  6'h3F, 6'h3F, "rst_diob_dir");
        push_exp(t, S_IIN,  6'h3F, 6'h00, "rst_internal_in");
        push_exp(t, S_LED2, 6'h3F, 6'h00, "rst_led2");
        push_exp(t, S_LED1, 6'h3F, 6'h00, "rst_led1");
        push_exp(t, S_ERR,  6'h01, 6'h00, "rst_err");
        push_exp(t, S_STK,  6'h01, 6'h00, "rst_sticky");
        tick(2);

        // Ch0 STRETCH L=5, single pulse -> high t+1..t+5
        set_mode(0, MODE_STRETCH);
        bus.stretch_len   = 16'd5;
        bus.output_enable = 6'h01;
        tick(3);
        t = cyc;
        push_exp(t, S_OUT, 6'h01, 6'h00, "str_pre");
        for (int k = 1; k <= 5; k++) push_exp(t + k, S_OUT, 6'h01, 6'h01, "str_high");
        push_exp(t + 6, S_OUT, 6'h01, 6'h00, "str_end");
        push_exp(t + 1, S_LED1, 6'h01, 6'h01, "led1_ch0");
        bus.internal_out[0] = 1'b1;
        tick(1);
        bus.internal_out[0] = 1'b0;
        tick(10);

        // Retrigger: pulses at t and t+3 -> high until t+8
        t = cyc;
        push_exp(t + 1, S_OUT, 6'h01, 6'h01, "retrig_first");
        push_exp(t + 4, S_OUT, 6'h01, 6'h01, "retrig_second");
        push_exp(t + 6, S_OUT, 6'h01, 6'h01, "retrig_past_first");
        push_exp(t + 8, S_OUT, 6'h01, 6'h01, "retrig_last");
        push_exp(t + 9, S_OUT, 6'h01, 6'h00, "retrig_end");
        bus.internal_out[0] = 1'b1;
        tick(1);
        bus.internal_out[0] = 1'b0;
        tick(2);
        bus.internal_out[0] = 1'b1;
        tick(1);
        bus.internal_out[0] = 1'b0;
        tick(12);

        // L=0 behaves as DIRECT
        bus.stretch_len = 16'd0;
        t = cyc;
        push_exp(t + 1, S_OUT, 6'h01, 6'h01, "l0_high");
        push_exp(t + 2, S_OUT, 6'h01, 6'h00, "l0_low");
        bus.internal_out[0] = 1'b1;
        tick(1);
        bus.internal_out[0] = 1'b0;
        tick(4);

        // Ch1 TOGGLE: three edges -> 1
        set_mode(1, MODE_TOGGLE);
        bus.output_enable = 6'h03;
        tick(2);
        t = cyc;
        push_exp(t + 1, S_OUT, 6'h02, 6'h02, "tog_e1");
        push_exp(t + 3, S_OUT, 6'h02, 6'h00, "tog_e2");
        push_exp(t + 5, S_OUT, 6'h02, 6'h02, "tog_e3");
        push_exp(t + 6, S_OUT, 6'h02, 6'h02, "tog_hold");
        for (int k = 0; k < 6; k++) begin
            bus.internal_out[1] = ((k % 2) == 0);
            tick(1);
        end
        // Drop enable for one cycle -> 0, state cleared, next edge -> 1
        u = cyc;
        push_exp(u + 1, S_OUT,  6'h02, 6'h00, "tog_oe_off");
        push_exp(u + 1, S_LED1, 6'h02, 6'h00, "led1_oe_off");
        push_exp(u + 2, S_OUT,  6'h02, 6'h00, "tog_cleared");
        push_exp(u + 3, S_OUT,  6'h02, 6'h02, "tog_after_clear");
        bus.output_enable[1] = 1'b0;
        tick(1);
        bus.output_enable[1] = 1'b1;
        tick(1);
        bus.internal_out[1] = 1'b1;
        tick(1);
        bus.internal_out[1] = 1'b0;
        tick(2);

        // Ch2 INVERT then DIRECT
        t = cyc;
        push_exp(t + 1, S_OUT, 6'h04, 6'h04, "inv_high");
        push_exp(t + 2, S_OUT, 6'h04, 6'h04, "inv_hold");
        push_exp(t + 3, S_OUT, 6'h04, 6'h00, "inv_to_direct");
        set_mode(2, MODE_INVERT);
        bus.output_enable   = 6'h07;
        bus.internal_out[2] = 1'b0;
        tick(2);
        set_mode(2, MODE_DIRECT);
        tick(3);

        // Ch3 activity LED: single change at t -> high t..t+3
        bus.output_enable = 6'h0F;
        tick(8);
        t = cyc + 1;
        push_exp(t - 1, S_LED2, 6'h08, 6'h00, "led_pre");
        push_exp(t,     S_LED2, 6'h08, 6'h08, "led_rise");
        push_exp(t + 3, S_LED2, 6'h08, 6'h08, "led_last");
        push_exp(t + 4, S_LED2, 6'h08, 6'h00, "led_off");
        push_exp(t + 5, S_LED2, 6'h08, 6'h00, "led_stay_off");
        bus.internal_out[3] = 1'b1;
        tick(8);
        // Changes at t and t+2 -> high t..t+5
        t = cyc + 1;
        push_exp(t - 1, S_LED2, 6'h08, 6'h00, "led2_pre");
        push_exp(t,     S_OUT,  6'h08, 6'h00, "led2_out_fall");
        push_exp(t,     S_LED2, 6'h08, 6'h08, "led2_rise");
        push_exp(t + 4, S_LED2, 6'h08, 6'h08, "led2_extended");
        push_exp(t + 5, S_LED2, 6'h08, 6'h08, "led2_last");
        push_exp(t + 6, S_LED2, 6'h08, 6'h00, "led2_off");
        bus.internal_out[3] = 1'b0;
        tick(2);
        bus.internal_out[3] = 1'b1;
        tick(10);

        // Async reset mid-stretch, first edge after release judged against prev=0
        bus.stretch_len = 16'd5;
        t = cyc;
        push_exp(t + 1, S_OUT, 6'h01, 6'h01, "prerst_high");
        bus.internal_out[0] = 1'b1;
        tick(2);
        nReset = 1'b0;
        push_exp(cyc, S_OUT,  6'h3F, 6'h00, "async_rst_out");
        push_exp(cyc, S_LED2, 6'h3F, 6'h00, "async_rst_led2");
        tick(1);
        nReset = 1'b1;
        r = cyc;
        push_exp(r + 1, S_OUT, 6'h01, 6'h01, "post_rst_edge");
        push_exp(r + 5, S_OUT, 6'h01, 6'h01, "post_rst_stretch");
        push_exp(r + 6, S_OUT, 6'h01, 6'h00, "post_rst_end");
        tick(1);
        bus.internal_out[0] = 1'b0;
        tick(8);

        // Errors: live, sticky, clear
        t = cyc;
        push_exp(t + 1, S_ERR, 6'h01, 6'h01, "err_live");
        push_exp(t + 1, S_STK, 6'h01, 6'h00, "err_sticky_pre");
        push_exp(t + 2, S_ERR, 6'h01, 6'h01, "err_live_hold");
        push_exp(t + 2, S_STK, 6'h01, 6'h01, "err_sticky_set");
        push_exp(t + 3, S_ERR, 6'h01, 6'h00, "err_live_clear");
        push_exp(t + 3, S_STK, 6'h01, 6'h01, "err_sticky_keep");
        push_exp(t + 4, S_STK, 6'h01, 6'h01, "err_sticky_keep2");
        push_exp(t + 6, S_STK, 6'h01, 6'h00, "err_sticky_clr");
        bus.input_enable  = 6'h01;
        bus.output_enable = 6'h00;
        tick(2);
        bus.input_enable  = 6'h00;
        bus.output_enable = 6'h0F;
        tick(3);
        bus.err_clr = 1'b1;
        tick(1);
        bus.err_clr = 1'b0;
        tick(2);
        // err_clr held with an active error: set wins
        t = cyc;
        push_exp(t + 1, S_ERR, 6'h01, 6'h01, "setwin_live");
        push_exp(t + 1, S_STK, 6'h01, 6'h00, "setwin_pre");
        push_exp(t + 2, S_STK, 6'h01, 6'h01, "setwin_set");
        push_exp(t + 4, S_STK, 6'h01, 6'h01, "setwin_hold");
        bus.input_enable  = 6'h01;
        bus.output_enable = 6'h00;
        bus.err_clr       = 1'b1;
        tick(4);
        bus.err_clr       = 1'b0;
        bus.input_enable  = 6'h00;
        bus.output_enable = 6'h0F;
        tick(2);

        push_exp(cyc, S_DIR, 6'h3F, 6'h3F, "end_diob_dir");
        push_exp(cyc, S_IIN, 6'h3F, 6'h00, "end_internal_in");

        // Drain the scoreboard within a bounded number of cycles
        for (int k = 0; (k < 20) && (sb.size() != 0); k++) tick(1);
        if (sb.size() != 0) begin
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb.size());
            errors += sb.size();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ibpl_out_ctrl.md
# ibpl_out_ctrl

Parametrised interbackplane output cardlet: drives N_CH backplane lines as outputs with a per-channel mode (direct, pulse-stretch, toggle, invert), gated by output enables. All driven outputs are registered. Each channel has a retriggerable activity-LED monostable, and the block reports live and sticky enable-mismatch errors. Sits in the DIOB2 frontend plugin slot, between the internal logic and the cardlet I/O pins.

## Interface
- N_CH, 6, number of channels (1..8)
- CNT_W, 16, width of the stretch length and stretch counter
- LED_HOLD, 125000, activity LED on-time in clk cycles (≥1)

Ports:
- clk  in  1  system clock
- nReset  in  1  asynchronous, active-low reset
- internal_out  in  N_CH  per-channel drive request from internal logic
- output_enable  in  N_CH  per-channel output enable
- input_enable  in  N_CH  per-channel input enable (error check only)
- ch_mode  in  2*N_CH  mode of channel i in bits [2i+1:2i]
- stretch_len  in  CNT_W  minimum high time in cycles for STRETCH mode, shared by all channels
- err_clr  in  1  single-cycle clear of the sticky error
- diob_dir  out  N_CH  constant all-ones (all outputs)
- diob_out  out  N_CH  registered line drive
- internal_in  out  N_CH  constant zero
- diob_led1  out  N_CH  registered copy of output_enable
- diob_led2  out  N_CH  activity LED, retriggerable
- plugin_error  out  1  registered live error
- plugin_error_sticky  out  1  latched error

## Operation
- Reset values: diob_out=0, diob_led1=0, diob_led2=0, plugin_error=0, plugin_error_sticky=0, all edge/toggle/counter state 0.
- Rising edge of channel i: internal_out[i] & ~prev[i]. prev is a registered copy of internal_out.
- Modes:
  - 0 DIRECT: core = internal_out.
  - 1 STRETCH: an edge loads the counter. core = internal_out | stretching.
  - 2 TOGGLE: core inverts on each edge.
  - 3 INVERT: core = ~internal_out.
- diob_out[i] is registered from output_enable[i] & core[i].
- STRETCH:
  - A single-cycle pulse at cycle t with stretch_len=L≥1 gives diob_out high for cycles t+1..t+L.
  - Input held high for longer than L: diob_out follows the input, and stretching adds no extension past it.
  - An edge during stretching reloads the counter (retrigger): last high cycle becomes t2+L.
  - L=0 behaves exactly as DIRECT.
  - stretch_len is sampled only at the edge.
- While output_enable[i]=0, the channel's toggle state and stretch counter are held cleared.
- A change of ch_mode[i] clears the channel's toggle state and stretch counter in that cycle.
- Activity LED: any change of diob_out[i] loads a LED counter with LED_HOLD. diob_led2[i] is high while the counter is nonzero.
  - A new change reloads the counter.
  - Counter width is $clog2(LED_HOLD+1).
- Errors:
  - plugin_error is registered from |(input_enable & ~output_enable).
  - plugin_error_sticky sets when plugin_error=1 and clears on err_clr.
  - Simultaneous set and err_clr: set wins.

## Timing
- Latency: internal_out → diob_out is 1 cycle in every mode.
- output_enable → diob_out, diob_led1 and plugin_error: 1 cycle each.
- diob_led2 rises in the same cycle as the diob_out change that triggered it, and stays high for exactly LED_HOLD cycles after the last change.
- TOGGLE: diob_out changes 1 cycle after each rising edge of internal_out.
- Reset mid-operation: all counters and outputs return to reset values asynchronously. The first edge after release is judged against prev=0.

## Structure
- Package ibpl_out_pkg holds:
  - typedef enum logic [1:0] ch_mode_t {MODE_DIRECT, MODE_STRETCH, MODE_TOGGLE, MODE_INVERT}
  - default parameter constants
- Sub-module ibpl_out_chan covers one channel: edge detect, mode mux, stretch counter, toggle state and LED counter.
  - It is generated N_CH times.
  - The top level holds error logic, diob_led1 and the constant outputs.

## Test plan
- Reset, then idle: diob_out=0, diob_dir=6'h3F, internal_in=0, diob_led2=0, plugin_error=0.
- Ch0 STRETCH, L=5, 1-cycle pulse at t=10 → diob_out[0] high for t=11..15. A second pulse at t=13 → high until t=18. With L=0 the same pulse gives a single high cycle.
- Ch1 TOGGLE, three rising edges → diob_out[1] ends at 1. Drop output_enable[1] for 1 cycle → diob_out[1]=0, toggle state cleared. The next edge drives it to 1.
- Ch2 INVERT with output_enable=1 and internal_out=0 → diob_out[2]=1. Switch to DIRECT → diob_out[2]=0 next cycle.
- LED_HOLD=4, a diob_out change at t → diob_led2 high t..t+3. A change at t+2 extends it to t+5.
- input_enable=6'h01, output_enable=0 → plugin_error=1 next cycle and sticky set. Restore the enables → live error clears, sticky stays. err_clr → sticky clears. err_clr held together with an active error → sticky stays 1.
